fpu_op_sequencer: RTL

//   Hardware initiator for the FPU: accepts operation requests over valid/ready,

---
 rtl/fpu_op_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
//   Hardware initiator for the FPU. Accepts one operation request over a
//   valid/ready port, registers the operands onto the FPU inputs, pulses
//   fpu_start_o for one cycle, then waits a fixed LATENCY and captures the
//   FPU result into a valid/ready response port. Only one operation is in
//   flight at a time. Running counts are kept of completed responses and of
//   those that carried an error or overflow flag.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   req_valid_i / req_ready_o  request handshake
//   req_a_i, req_b_i           IEEE-754 single operands
//   req_sel_i, req_round_i     op select / rounding mode, passed through
//   fpu_a_o .. fpu_round_o     registered operands to the FPU
//   fpu_start_o                one-cycle start pulse to the FPU
//   fpu_y_i, fpu_overflow_i,
//   fpu_error_i                FPU result and flags
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_y_o, rsp_overflow_o,
//   rsp_error_o                captured FPU result and flags
//   busy_o                     high whenever not idle
//   op_count_o, err_count_o    wrapping completion / error counters

module fpu_op_sequencer #(
  parameter int LATENCY = 10,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [1:0]       req_sel_i,
  input  logic [1:0]       req_round_i,
  output logic [31:0]      fpu_a_o,
  output logic [31:0]      fpu_b_o,
  output logic [1:0]       fpu_sel_o,
  output logic [1:0]       fpu_round_o,
  output logic             fpu_start_o,
  input  logic [31:0]      fpu_y_i,
  input  logic             fpu_overflow_i,
  input  logic             fpu_error_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_y_o,
  output logic             rsp_overflow_o,
  output logic             rsp_error_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  // Wait counter only has to hold LATENCY-1; keep at least one bit so a
  // LATENCY of 1 still elaborates.
  localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic [31:0]      fpu_a_q, fpu_a_d;
  logic [31:0]      fpu_b_q, fpu_b_d;
  logic [1:0]       fpu_sel_q, fpu_sel_d;
  logic [1:0]       fpu_round_q, fpu_round_d;
  logic             fpu_start_q, fpu_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_y_q, rsp_y_d;
  logic             rsp_overflow_q, rsp_overflow_d;
  logic             rsp_error_q, rsp_error_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Next-state logic. Every output is a register, so the decisions for the
  // following cycle's outputs (ready, busy, start, valid) are made here
  // together with the state transition.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    req_ready_d    = req_ready_q;
    busy_d         = busy_q;
    fpu_a_d        = fpu_a_q;
    fpu_b_d        = fpu_b_q;
    fpu_sel_d      = fpu_sel_q;
    fpu_round_d    = fpu_round_q;
    fpu_start_d    = 1'b0;
    rsp_valid_d    = rsp_valid_q;
    rsp_y_d        = rsp_y_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_error_d    = rsp_error_q;
    op_count_d     = op_count_q;
    err_count_d    = err_count_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          fpu_a_d     = req_a_i;
          fpu_b_d     = req_b_i;
          fpu_sel_d   = req_sel_i;
          fpu_round_d = req_round_i;
          fpu_start_d = 1'b1;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ISSUE;
        end
      end

      // The count runs from the ISSUE edge, so a load of LATENCY-1 lands the
      // capture exactly LATENCY edges later; LATENCY==1 loads 0 and captures
      // on the first WAIT edge without a special case.
      ISSUE: begin
        wait_d  = WAIT_LOAD;
        state_d = WAIT;
      end

      WAIT: begin
        if (wait_q == '0) begin
          rsp_y_d        = fpu_y_i;
          rsp_overflow_d = fpu_overflow_i;
          rsp_error_d    = fpu_error_i;
          rsp_valid_d    = 1'b1;
          state_d        = RESP;
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end

      // Ready is only raised for the cycle after the handshake, so no request
      // can be taken in the same cycle the response retires.
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          if (rsp_error_q || rsp_overflow_q) begin
            err_count_d = err_count_q + CNT_W'(1);
          end
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State registers. Reset aborts any operation in flight and drops a
  // pending response without touching it into the counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      wait_q         <= '0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      fpu_a_q        <= '0;
      fpu_b_q        <= '0;
      fpu_sel_q      <= '0;
      fpu_round_q    <= '0;
      fpu_start_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_y_q        <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_error_q    <= 1'b0;
      op_count_q     <= '0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      req_ready_q    <= req_ready_d;
      busy_q         <= busy_d;
      fpu_a_q        <= fpu_a_d;
      fpu_b_q        <= fpu_b_d;
      fpu_sel_q      <= fpu_sel_d;
      fpu_round_q    <= fpu_round_d;
      fpu_start_q    <= fpu_start_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_y_q        <= rsp_y_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_error_q    <= rsp_error_d;
      op_count_q     <= op_count_d;
      err_count_q    <= err_count_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign busy_o         = busy_q;
  assign fpu_a_o        = fpu_a_q;
  assign fpu_b_o        = fpu_b_q;
  assign fpu_sel_o      = fpu_sel_q;
  assign fpu_round_o    = fpu_round_q;
  assign fpu_start_o    = fpu_start_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_y_o        = rsp_y_q;
  assign rsp_overflow_o = rsp_overflow_q;
  assign rsp_error_o    = rsp_error_q;
  assign op_count_o     = op_count_q;
  assign err_count_o    = err_count_q;

endmodule
